// File: rtl/pc_redirect_sequencer.sv
// pc_redirect_sequencer: fetch PC owner and control-flow redirect sequencer (optional perf counters via PC_REDIRECT_PERF_EN)
module pc_redirect_sequencer #(
  parameter int XLEN = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ex_valid,
  input  logic [1:0]      ex_branch_ctrl,
  input  logic [XLEN-1:0] ex_pc_imm,
  input  logic [XLEN-1:0] ex_jalr_target,
  input  logic            stall_in,
  input  logic            im_ready,
  output logic [XLEN-1:0] pc_out,
  output logic            im_req,
  output logic            flush_if_id,
  output logic            flush_id_ex,
  output logic            redirect_busy,
`ifdef PC_REDIRECT_PERF_EN
  output logic [31:0]     redirect_cnt,
  output logic [31:0]     redir_stall_cnt,
`endif
  output logic            misalign
);
  typedef enum logic {RUN, REDIR} state_t;
  state_t state, state_n;
  logic [XLEN-1:0] tgt, pc_n;
  logic rst_q, accept, advance;
  // next state and next PC; a redirect wins over the sequential step, which is held off until fetch is requested
  always_comb begin
    tgt = ex_branch_ctrl[1] ? ex_pc_imm : (ex_jalr_target & ~XLEN'(1));
    accept = state == RUN && ex_valid && !stall_in && (ex_branch_ctrl == 2'b10 || ex_branch_ctrl == 2'b01);
    advance = im_ready && !stall_in && !rst_q;
    state_n = accept ? REDIR : (state == REDIR && advance) ? RUN : state;
    pc_n = accept ? (tgt & ~XLEN'(3)) : advance ? pc_out + XLEN'(4) : pc_out;
  end
  // state, PC and one-cycle pulse registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      pc_out <= RESET_PC;
      rst_q <= 1'b1;
      flush_id_ex <= 1'b0;
      misalign <= 1'b0;
    end else begin
      state <= state_n;
      pc_out <= pc_n;
      rst_q <= 1'b0;
      flush_id_ex <= accept;
      misalign <= accept && tgt[1];
    end
  end
  assign im_req = ~rst_q;
  assign flush_if_id = state == REDIR;
  assign redirect_busy = state == REDIR;
`ifdef PC_REDIRECT_PERF_EN
  // accepted-redirect and REDIR-cycle counters, wrapping naturally
  always_ff @(posedge clk) begin
    if (rst) begin
      redirect_cnt <= '0;
      redir_stall_cnt <= '0;
    end else begin
      redirect_cnt <= redirect_cnt + 32'(accept);
      redir_stall_cnt <= redir_stall_cnt + 32'(state == REDIR);
    end
  end
`endif
endmodule

// File: tb/tb_pc_redirect_sequencer.sv
// tb_pc_redirect_sequencer: vector table, directed corner sequences and randomized model check
module tb_pc_redirect_sequencer;
  logic clk = 0, rst = 1, ex_valid = 0, stall_in = 0, im_ready = 0;
  logic [1:0] ex_branch_ctrl = 0;
  logic [31:0] ex_pc_imm = 0, ex_jalr_target = 0, pc_out;
  logic im_req, flush_if_id, flush_id_ex, redirect_busy, misalign;
`ifdef PC_REDIRECT_PERF_EN
  logic [31:0] redirect_cnt, redir_stall_cnt;
`endif
  int n_pass = 0, n_tot = 0;
  logic [31:0] m_pc = 0, m_rc = 0, m_sc = 0;
  logic m_busy = 0, m_fie = 0, m_mis = 0, m_req = 0;

  pc_redirect_sequencer #(.XLEN(32), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_branch_ctrl(ex_branch_ctrl),
    .ex_pc_imm(ex_pc_imm), .ex_jalr_target(ex_jalr_target), .stall_in(stall_in),
    .im_ready(im_ready), .pc_out(pc_out), .im_req(im_req), .flush_if_id(flush_if_id),
    .flush_id_ex(flush_id_ex), .redirect_busy(redirect_busy),
`ifdef PC_REDIRECT_PERF_EN
    .redirect_cnt(redirect_cnt), .redir_stall_cnt(redir_stall_cnt),
`endif
    .misalign(misalign));

  always #5 clk = ~clk;

  typedef struct {
    logic r; logic v; logic [1:0] c; logic [31:0] imm; logic [31:0] jt; logic s; logic ir;
    logic [31:0] pc; logic fif; logic fie; logic busy; logic mis; logic req;
  } vec_t;
  vec_t tbl[18];

  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", n, act, exp);
  endtask

  task automatic chk_all(string n, logic [31:0] pc, logic fif, logic fie, logic busy, logic mis, logic req);
    chk({n, ".pc"}, pc_out, pc);
    chk({n, ".flush_if_id"}, 32'(flush_if_id), 32'(fif));
    chk({n, ".flush_id_ex"}, 32'(flush_id_ex), 32'(fie));
    chk({n, ".busy"}, 32'(redirect_busy), 32'(busy));
    chk({n, ".misalign"}, 32'(misalign), 32'(mis));
    chk({n, ".im_req"}, 32'(im_req), 32'(req));
  endtask

  // reference: redirect accepted only when idle, unstalled and the decision is a jump; fetch advances by 4 per completed fetch
  task automatic step(logic r, logic v, logic [1:0] c, logic [31:0] imm, logic [31:0] jt, logic s, logic ir);
    logic acc;
    logic [31:0] t;
    rst = r; ex_valid = v; ex_branch_ctrl = c; ex_pc_imm = imm; ex_jalr_target = jt; stall_in = s; im_ready = ir;
    @(posedge clk);
    if (r) begin
      m_pc = 0; m_busy = 0; m_fie = 0; m_mis = 0; m_req = 0; m_rc = 0; m_sc = 0;
    end else begin
      acc = !m_busy && v && !s && (c == 2'b10 || c == 2'b01);
      t = c[1] ? imm : (jt & ~32'd1);
      m_sc = m_sc + 32'(m_busy);
      if (acc) begin m_pc = t & ~32'd3; m_busy = 1; m_rc = m_rc + 1; end
      else if (m_req && ir && !s) begin m_pc = m_pc + 4; m_busy = 0; end
      m_fie = acc; m_mis = acc && t[1]; m_req = 1;
    end
    #1;
  endtask

  task automatic idle(logic ir); step(0, 0, 2'b00, 0, 0, 0, ir); endtask

  initial begin
    tbl[0]  = '{1,0,2'b00,0,0,0,1, 32'h0,0,0,0,0,0};
    tbl[1]  = '{1,0,2'b00,0,0,0,1, 32'h0,0,0,0,0,0};
    tbl[2]  = '{1,0,2'b00,0,0,0,1, 32'h0,0,0,0,0,0};
    tbl[3]  = '{0,0,2'b00,0,0,0,1, 32'h0,0,0,0,0,1};
    tbl[4]  = '{0,0,2'b00,0,0,0,1, 32'h4,0,0,0,0,1};
    tbl[5]  = '{0,0,2'b00,0,0,0,1, 32'h8,0,0,0,0,1};
    tbl[6]  = '{0,0,2'b00,0,0,0,1, 32'hC,0,0,0,0,1};
    tbl[7]  = '{0,0,2'b00,0,0,0,1, 32'h10,0,0,0,0,1};
    tbl[8]  = '{0,1,2'b10,32'h100,0,0,1, 32'h100,1,1,1,0,1};
    tbl[9]  = '{0,0,2'b00,0,0,0,1, 32'h104,0,0,0,0,1};
    tbl[10] = '{0,1,2'b01,0,32'h2003,0,1, 32'h2000,1,1,1,1,1};
    tbl[11] = '{0,0,2'b00,0,0,0,1, 32'h2004,0,0,0,0,1};
    tbl[12] = '{0,1,2'b11,32'h5000,32'h6000,0,1, 32'h2008,0,0,0,0,1};
    tbl[13] = '{0,1,2'b10,32'h2008,0,0,1, 32'h2008,1,1,1,0,1};
    tbl[14] = '{0,0,2'b00,0,0,0,1, 32'h200C,0,0,0,0,1};
    tbl[15] = '{0,1,2'b10,32'hFFFF_FFFE,0,0,1, 32'hFFFF_FFFC,1,1,1,1,1};
    tbl[16] = '{0,0,2'b00,0,0,0,1, 32'h0,0,0,0,0,1};
    tbl[17] = '{0,1,2'b00,32'h700,32'h800,0,0, 32'h0,0,0,0,0,1};
    for (int i = 0; i < 18; i++) begin
      step(tbl[i].r, tbl[i].v, tbl[i].c, tbl[i].imm, tbl[i].jt, tbl[i].s, tbl[i].ir);
      chk_all($sformatf("vec%0d", i), tbl[i].pc, tbl[i].fif, tbl[i].fie, tbl[i].busy, tbl[i].mis, tbl[i].req);
    end
    // slow instruction memory during redirect
    step(0, 1, 2'b10, 32'h40, 0, 0, 0);
    chk_all("slow.acc", 32'h40, 1, 1, 1, 0, 1);
    for (int i = 0; i < 3; i++) begin
      idle(0);
      chk_all($sformatf("slow.wait%0d", i), 32'h40, 1, 0, 1, 0, 1);
    end
    idle(1);
    chk_all("slow.done", 32'h44, 0, 0, 0, 0, 1);
    // stall blocks acceptance until it drops
    for (int i = 0; i < 2; i++) begin
      step(0, 1, 2'b10, 32'h80, 0, 1, 1);
      chk_all($sformatf("stall.blk%0d", i), 32'h44, 0, 0, 0, 0, 1);
    end
    step(0, 1, 2'b10, 32'h80, 0, 0, 1);
    chk_all("stall.acc", 32'h80, 1, 1, 1, 0, 1);
    idle(1);
    chk_all("stall.done", 32'h84, 0, 0, 0, 0, 1);
    // stall while the target fetch completes keeps REDIR
    step(0, 1, 2'b10, 32'h200, 0, 0, 1);
    step(0, 0, 2'b00, 0, 0, 1, 1);
    chk_all("rstall.hold", 32'h200, 1, 0, 1, 0, 1);
    idle(1);
    chk_all("rstall.done", 32'h204, 0, 0, 0, 0, 1);
    // reset in the second REDIR cycle
    step(0, 1, 2'b10, 32'h300, 0, 0, 0);
    idle(0);
    step(1, 0, 2'b00, 0, 0, 0, 0);
    chk_all("midrst", 32'h0, 0, 0, 0, 0, 0);
`ifdef PC_REDIRECT_PERF_EN
    chk("midrst.rcnt", redirect_cnt, 32'h0);
    chk("midrst.scnt", redir_stall_cnt, 32'h0);
`endif
    idle(1);
    chk_all("midrst.resume", 32'h0, 0, 0, 0, 0, 1);
    // randomized traffic against the reference
    for (int i = 0; i < 500; i++) begin
      step($urandom_range(0, 49) == 0, !m_busy && $urandom_range(0, 1) == 1, 2'($urandom),
           $urandom, $urandom, $urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0);
      chk_all($sformatf("rnd%0d", i), m_pc, m_busy, m_fie, m_busy, m_mis, m_req);
`ifdef PC_REDIRECT_PERF_EN
      chk($sformatf("rnd%0d.rcnt", i), redirect_cnt, m_rc);
      chk($sformatf("rnd%0d.scnt", i), redir_stall_cnt, m_sc);
`endif
    end
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule

// File: doc/pc_redirect_sequencer.md
Name: pc_redirect_sequencer

Overview:
Owns the fetch PC of the 5-stage RV32 core and sequences control-flow redirects. Consumes the 2-bit branch-control decision from EX (00 = PC+4, 10 = PC+imm for taken B-type or JAL, 01 = JALR).
- Updates the PC from that decision.
- Drives the instruction-memory fetch request.
- Generates IF/ID and ID/EX flushes until the first instruction from the new target returns.

Parameters:
RESET_PC, 32'h0000_0000, fetch address loaded on reset
XLEN, 32, address/data width

Ports:
clk  in  1  core clock; all state updates on rising edge
rst  in  1  synchronous reset, active-high
ex_valid  in  1  EX stage holds a real (non-bubble) instruction
ex_branch_ctrl  in  2  00 PC+4, 10 PC+imm, 01 JALR, 11 reserved (treated as 00)
ex_pc_imm  in  XLEN  PC+imm target from EX adder
ex_jalr_target  in  XLEN  rs1+imm from ALU
stall_in  in  1  pipeline freeze (load-use / data-memory wait)
im_ready  in  1  fetch of current pc_out completes this cycle
pc_out  out  XLEN  current fetch address
im_req  out  1  fetch request valid
flush_if_id  out  1  squash IF/ID register contents
flush_id_ex  out  1  squash ID/EX register contents
redirect_busy  out  1  high while in REDIR state
misalign  out  1  one-cycle pulse: accepted target had bit1 set

Behaviour:
- Reset, sampled on the clk edge with rst=1, overrides everything:
  - pc_out=RESET_PC, state=RUN, im_req=0.
  - flush_if_id=0, flush_id_ex=0, redirect_busy=0, misalign=0.
  - im_req rises in the first cycle after rst deasserts.
- Accepted redirect:
  - Condition: ex_valid=1, stall_in=0, ex_branch_ctrl is 10 or 01.
  - Target for 10: ex_pc_imm.
  - Target for 01: ex_jalr_target with bit0 forced to 0.
  - Target bits [1:0] are cleared before loading into pc_out. If the (post bit0-clear) target bit1 was 1, misalign pulses the cycle after acceptance.
- State RUN:
  - If no redirect, im_ready=1 and stall_in=0: pc_out <= pc_out+4 (wraps modulo 2^XLEN).
  - If im_ready=0 or stall_in=1: pc_out holds.
  - On an accepted redirect at cycle N: pc_out=target at N+1, state=REDIR at N+1. A redirect has priority over the sequential increment in the same cycle.
- State REDIR:
  - flush_id_ex=1 for exactly one cycle (N+1).
  - flush_if_id=1 for every REDIR cycle, including N+1.
  - redirect_busy=1 in every REDIR cycle.
  - im_req stays 1; pc_out holds target until im_ready=1.
  - On im_ready=1 with stall_in=0: pc_out <= target+4, state -> RUN; flush_if_id drops the following cycle.
  - On im_ready=1 with stall_in=1: remain in REDIR, pc_out holds.
  - ex_valid is guaranteed 0 here (ID/EX flushed); any ex_branch_ctrl is ignored.
- Simultaneous events:
  - stall_in=1 blocks redirect acceptance; the EX instruction is re-presented next cycle.
  - A redirect whose target equals pc_out is still a full redirect (flush, REDIR).
- Reset mid-REDIR: state, pc_out and flushes return to reset values the next cycle; the pending target is discarded.
- All outputs are registered except im_req (=~rst_q, i.e. registered too). No combinational path from inputs to outputs.

Optional Feature:
- Macro PC_REDIRECT_PERF_EN.
- When defined, adds output redirect_cnt [31:0] and output redir_stall_cnt [31:0].
  - redirect_cnt increments once per accepted redirect.
  - redir_stall_cnt increments every cycle in REDIR.
  - Both reset to 0 and wrap at 2^32.
- When undefined, neither port nor the counters exist; all other behaviour is identical.

Test Plan:
1. Reset: rst=1 for 3 cycles, then 0 with im_ready=1 -> pc_out=0x0, then 0x4, 0x8 on successive cycles; flushes 0.
2. JAL/taken branch: at pc 0x10, ex_valid=1, ctrl=10, ex_pc_imm=0x100, im_ready=1 -> next cycle pc_out=0x100, flush_id_ex=1 (1 cycle), flush_if_id=1; following cycle pc_out=0x104, state RUN.
3. JALR: ctrl=01, ex_jalr_target=0x2003 -> pc_out=0x2000, misalign=1 for one cycle.
4. Slow IM: redirect to 0x40 with im_ready low 3 cycles -> pc_out=0x40 and flush_if_id=1 for 4 cycles, redirect_busy=1 throughout, then pc_out=0x44.
5. Stall interlock: ctrl=10 with stall_in=1 for 2 cycles -> no redirect, pc_out holds; stall_in drops -> redirect taken next cycle.
6. Reset during REDIR: assert rst in second REDIR cycle -> pc_out=RESET_PC, flushes 0, redirect_busy=0 next cycle; with PC_REDIRECT_PERF_EN, counters read 0.
